// File: rtl/rs_pkg.sv
// Shared types, defaults and operand wakeup helper for the reservation station.
package rs_pkg;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned DEPTH = 8;

  localparam logic [3:0]       OP_LW  = 4'b0100;
  localparam logic [3:0]       OP_SW  = 4'b0101;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [15:0]      data;
    logic             valid;
  } rs_opnd_t;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [2:0]       alu_op;
    logic [1:0]       cz;
    logic [15:0]      imm;
    logic [15:0]      pc;
    logic             alu_en;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             branch;
    logic             jump;
    logic             cmp;
    logic [TAG_W-1:0] rrf_dest;
  } rs_payload_t;

  typedef struct packed {
    logic        valid;
    rs_payload_t pay;
    rs_opnd_t    a;
    rs_opnd_t    b;
  } rs_entry_t;

  typedef struct packed {
    rs_payload_t pay;
    logic [15:0] data_a;
    logic [15:0] data_b;
  } rs_issue_t;

  // Bus 1 has priority when both broadcasts carry the awaited tag.
  function automatic rs_opnd_t rs_wakeup(rs_opnd_t op,
                                         logic v1, logic [TAG_W-1:0] t1, logic [15:0] d1,
                                         logic v2, logic [TAG_W-1:0] t2, logic [15:0] d2);
    rs_opnd_t r;
    r = op;
    if (!op.valid && op.tag != NO_TAG) begin
      if (v1 && t1 == op.tag) begin
        r.data  = d1;
        r.valid = 1'b1;
      end else if (v2 && t2 == op.tag) begin
        r.data  = d2;
        r.valid = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix over the station entries; grants the oldest ready entry one-hot.
module rs_age_select #(
  parameter int unsigned DEPTH = rs_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc_1_i,
  input  logic [DEPTH-1:0] alloc_2_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_o
);

  // age_q[i][j] set means entry i is older than entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic             blocked;

  // Slot 2 is applied after slot 1 so it ends up younger than slot 1.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        age_d[i][j] = age_q[i][j];
        if (free_i[i])    age_d[i][j] = 1'b0;
        if (alloc_1_i[i]) age_d[i][j] = 1'b0;
        if (alloc_1_i[j]) age_d[i][j] = 1'b1;
        if (alloc_2_i[i]) age_d[i][j] = 1'b0;
        if (alloc_2_i[j]) age_d[i][j] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    blocked = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      blocked = 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j != i && ready_i[j] && age_q[j][i]) blocked = 1'b1;
      end
      grant_o[i] = ready_i[i] && !blocked;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: two-wide dispatch, CDB wakeup, oldest-ready issue.
module reservation_station #(
  parameter int unsigned DEPTH = rs_pkg::DEPTH,
  parameter int unsigned TAG_W = rs_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rs_valid_1,
  input  logic [3:0]       rs_opcode_1,
  input  logic [2:0]       rs_alu_op_1,
  input  logic [1:0]       rs_cz_1,
  input  logic [TAG_W-1:0] rs_tag_a_1,
  input  logic [TAG_W-1:0] rs_tag_b_1,
  input  logic [15:0]      rs_data_a_1,
  input  logic [15:0]      rs_data_b_1,
  input  logic             rs_valid_a_1,
  input  logic             rs_valid_b_1,
  input  logic [15:0]      rs_imm_1,
  input  logic [15:0]      rs_pc_1,
  input  logic             rs_alu_en_1,
  input  logic             rs_mem_read_1,
  input  logic             rs_mem_write_1,
  input  logic             rs_reg_write_1,
  input  logic             rs_branch_1,
  input  logic             rs_jump_1,
  input  logic             rs_cmp_1,
  input  logic [TAG_W-1:0] rs_rrf_dest_1,
  input  logic             rs_valid_2,
  input  logic [3:0]       rs_opcode_2,
  input  logic [2:0]       rs_alu_op_2,
  input  logic [1:0]       rs_cz_2,
  input  logic [TAG_W-1:0] rs_tag_a_2,
  input  logic [TAG_W-1:0] rs_tag_b_2,
  input  logic [15:0]      rs_data_a_2,
  input  logic [15:0]      rs_data_b_2,
  input  logic             rs_valid_a_2,
  input  logic             rs_valid_b_2,
  input  logic [15:0]      rs_imm_2,
  input  logic [15:0]      rs_pc_2,
  input  logic             rs_alu_en_2,
  input  logic             rs_mem_read_2,
  input  logic             rs_mem_write_2,
  input  logic             rs_reg_write_2,
  input  logic             rs_branch_2,
  input  logic             rs_jump_2,
  input  logic             rs_cmp_2,
  input  logic [TAG_W-1:0] rs_rrf_dest_2,
  input  logic             cdb_valid_1,
  input  logic [TAG_W-1:0] cdb_tag_1,
  input  logic [15:0]      cdb_data_1,
  input  logic             cdb_valid_2,
  input  logic [TAG_W-1:0] cdb_tag_2,
  input  logic [15:0]      cdb_data_2,
  output logic             rs_full,
  output logic             rs_has_one_slot,
  input  logic             iss_ready,
  output logic             iss_valid,
  output logic [3:0]       iss_opcode,
  output logic [15:0]      iss_data_a,
  output logic [15:0]      iss_data_b,
  output logic [15:0]      iss_imm,
  output logic [15:0]      iss_pc,
  output logic [TAG_W-1:0] iss_rrf_dest,
  output logic             iss_alu_en,
  output logic [2:0]       iss_alu_op,
  output logic             iss_mem_read,
  output logic             iss_mem_write,
  output logic             iss_reg_write,
  output logic             iss_branch,
  output logic             iss_jump,
  output logic [1:0]       iss_cz,
  output logic             iss_cmp
);
  import rs_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rs_entry_t        entry_q [DEPTH];
  rs_entry_t        entry_d [DEPTH];
  rs_entry_t        new_1, new_2;
  rs_issue_t        iss_q, iss_d;
  logic             iss_valid_q, iss_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, one_slot_q, one_slot_d;

  logic [DEPTH-1:0] free_vec, first_oh, second_oh, slot_2_oh;
  logic [DEPTH-1:0] alloc_1_oh, alloc_2_oh, ready_vec, grant_oh, issue_oh;
  logic             acc_1, acc_2, iss_load;

  always_comb begin
    new_1 = '0;
    new_1.valid         = 1'b1;
    new_1.pay.opcode    = rs_opcode_1;
    new_1.pay.alu_op    = rs_alu_op_1;
    new_1.pay.cz        = rs_cz_1;
    new_1.pay.imm       = rs_imm_1;
    new_1.pay.pc        = rs_pc_1;
    new_1.pay.alu_en    = rs_alu_en_1;
    new_1.pay.mem_read  = rs_mem_read_1;
    new_1.pay.mem_write = rs_mem_write_1;
    new_1.pay.reg_write = rs_reg_write_1;
    new_1.pay.branch    = rs_branch_1;
    new_1.pay.jump      = rs_jump_1;
    new_1.pay.cmp       = rs_cmp_1;
    new_1.pay.rrf_dest  = rs_rrf_dest_1;
    new_1.a = '{tag: rs_tag_a_1, data: rs_data_a_1, valid: rs_valid_a_1};
    new_1.b = '{tag: rs_tag_b_1, data: rs_data_b_1, valid: rs_valid_b_1};
    new_1.a = rs_wakeup(new_1.a, cdb_valid_1, cdb_tag_1, cdb_data_1,
                        cdb_valid_2, cdb_tag_2, cdb_data_2);
    new_1.b = rs_wakeup(new_1.b, cdb_valid_1, cdb_tag_1, cdb_data_1,
                        cdb_valid_2, cdb_tag_2, cdb_data_2);
  end

  always_comb begin
    new_2 = '0;
    new_2.valid         = 1'b1;
    new_2.pay.opcode    = rs_opcode_2;
    new_2.pay.alu_op    = rs_alu_op_2;
    new_2.pay.cz        = rs_cz_2;
    new_2.pay.imm       = rs_imm_2;
    new_2.pay.pc        = rs_pc_2;
    new_2.pay.alu_en    = rs_alu_en_2;
    new_2.pay.mem_read  = rs_mem_read_2;
    new_2.pay.mem_write = rs_mem_write_2;
    new_2.pay.reg_write = rs_reg_write_2;
    new_2.pay.branch    = rs_branch_2;
    new_2.pay.jump      = rs_jump_2;
    new_2.pay.cmp       = rs_cmp_2;
    new_2.pay.rrf_dest  = rs_rrf_dest_2;
    new_2.a = '{tag: rs_tag_a_2, data: rs_data_a_2, valid: rs_valid_a_2};
    new_2.b = '{tag: rs_tag_b_2, data: rs_data_b_2, valid: rs_valid_b_2};
    new_2.a = rs_wakeup(new_2.a, cdb_valid_1, cdb_tag_1, cdb_data_1,
                        cdb_valid_2, cdb_tag_2, cdb_data_2);
    new_2.b = rs_wakeup(new_2.b, cdb_valid_1, cdb_tag_1, cdb_data_1,
                        cdb_valid_2, cdb_tag_2, cdb_data_2);
  end

  // Free status is taken from the registered state, so an entry issued this
  // cycle only becomes allocatable next cycle.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    first_oh  = '0;
    second_oh = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      free_vec[i]  = !entry_q[i].valid;
      ready_vec[i] = entry_q[i].valid && entry_q[i].a.valid && entry_q[i].b.valid;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (free_vec[i]) begin
        if (first_oh == '0)       first_oh[i]  = 1'b1;
        else if (second_oh == '0) second_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_2_oh  = rs_valid_1 ? second_oh : first_oh;
    acc_1      = rs_valid_1 && !flush && (first_oh != '0);
    acc_2      = rs_valid_2 && !flush && (slot_2_oh != '0);
    alloc_1_oh = acc_1 ? first_oh : '0;
    alloc_2_oh = acc_2 ? slot_2_oh : '0;
    iss_load   = !flush && (!iss_valid_q || iss_ready) && (ready_vec != '0);
    issue_oh   = iss_load ? grant_oh : '0;
  end

  rs_age_select #(
    .DEPTH(DEPTH)
  ) u_age_select (
    .clk       (clk),
    .rst       (rst),
    .alloc_1_i (alloc_1_oh),
    .alloc_2_i (alloc_2_oh),
    .free_i    (issue_oh),
    .ready_i   (ready_vec),
    .grant_o   (grant_oh)
  );

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid) begin
        entry_d[i].a = rs_wakeup(entry_q[i].a, cdb_valid_1, cdb_tag_1, cdb_data_1,
                                 cdb_valid_2, cdb_tag_2, cdb_data_2);
        entry_d[i].b = rs_wakeup(entry_q[i].b, cdb_valid_1, cdb_tag_1, cdb_data_1,
                                 cdb_valid_2, cdb_tag_2, cdb_data_2);
      end
      if (issue_oh[i])   entry_d[i].valid = 1'b0;
      if (alloc_1_oh[i]) entry_d[i] = new_1;
      if (alloc_2_oh[i]) entry_d[i] = new_2;
      if (flush)         entry_d[i].valid = 1'b0;
    end
  end

  // Operand data comes from storage only; a same-cycle broadcast is not forwarded.
  always_comb begin
    iss_d = iss_q;
    if (iss_load) begin
      iss_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (grant_oh[i]) begin
          iss_d.pay    = entry_q[i].pay;
          iss_d.data_a = entry_q[i].a.data;
          iss_d.data_b = entry_q[i].b.data;
        end
      end
    end
    if (flush)         iss_valid_d = 1'b0;
    else if (iss_load) iss_valid_d = 1'b1;
    else if (iss_ready) iss_valid_d = 1'b0;
    else               iss_valid_d = iss_valid_q;
  end

  always_comb begin
    if (flush) count_d = '0;
    else count_d = count_q + CNT_W'(acc_1) + CNT_W'(acc_2) - CNT_W'(iss_load);
    full_d     = (count_d == CNT_W'(DEPTH));
    one_slot_d = (count_d == CNT_W'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      one_slot_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
      count_q     <= count_d;
      full_q      <= full_d;
      one_slot_q  <= one_slot_d;
    end
  end

  // Dispatch must never overrun the free entries.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert ((!rs_valid_1 || acc_1) && (!rs_valid_2 || acc_2));
    end
  end

  assign rs_full         = full_q;
  assign rs_has_one_slot = one_slot_q;
  assign iss_valid       = iss_valid_q;
  assign iss_opcode      = iss_q.pay.opcode;
  assign iss_data_a      = iss_q.data_a;
  assign iss_data_b      = iss_q.data_b;
  assign iss_imm         = iss_q.pay.imm;
  assign iss_pc          = iss_q.pay.pc;
  assign iss_rrf_dest    = iss_q.pay.rrf_dest;
  assign iss_alu_en      = iss_q.pay.alu_en;
  assign iss_alu_op      = iss_q.pay.alu_op;
  assign iss_mem_read    = iss_q.pay.mem_read;
  assign iss_mem_write   = iss_q.pay.mem_write;
  assign iss_reg_write   = iss_q.pay.reg_write;
  assign iss_branch      = iss_q.pay.branch;
  assign iss_jump        = iss_q.pay.jump;
  assign iss_cz          = iss_q.pay.cz;
  assign iss_cmp         = iss_q.pay.cmp;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: issue order, wakeup, occupancy, flush.
module tb_reservation_station;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic rst, flush, iss_ready;
  logic rs_valid_1, rs_valid_a_1, rs_valid_b_1, rs_alu_en_1, rs_mem_read_1, rs_mem_write_1;
  logic rs_reg_write_1, rs_branch_1, rs_jump_1, rs_cmp_1;
  logic [3:0] rs_opcode_1;
  logic [2:0] rs_alu_op_1;
  logic [1:0] rs_cz_1;
  logic [TAG_W-1:0] rs_tag_a_1, rs_tag_b_1, rs_rrf_dest_1;
  logic [15:0] rs_data_a_1, rs_data_b_1, rs_imm_1, rs_pc_1;
  logic rs_valid_2, rs_valid_a_2, rs_valid_b_2, rs_alu_en_2, rs_mem_read_2, rs_mem_write_2;
  logic rs_reg_write_2, rs_branch_2, rs_jump_2, rs_cmp_2;
  logic [3:0] rs_opcode_2;
  logic [2:0] rs_alu_op_2;
  logic [1:0] rs_cz_2;
  logic [TAG_W-1:0] rs_tag_a_2, rs_tag_b_2, rs_rrf_dest_2;
  logic [15:0] rs_data_a_2, rs_data_b_2, rs_imm_2, rs_pc_2;
  logic cdb_valid_1, cdb_valid_2;
  logic [TAG_W-1:0] cdb_tag_1, cdb_tag_2;
  logic [15:0] cdb_data_1, cdb_data_2;
  logic rs_full, rs_has_one_slot, iss_valid;
  logic [3:0] iss_opcode;
  logic [15:0] iss_data_a, iss_data_b, iss_imm, iss_pc;
  logic [TAG_W-1:0] iss_rrf_dest;
  logic iss_alu_en, iss_mem_read, iss_mem_write, iss_reg_write, iss_branch, iss_jump, iss_cmp;
  logic [2:0] iss_alu_op;
  logic [1:0] iss_cz;

  reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rs_valid_1(rs_valid_1), .rs_opcode_1(rs_opcode_1), .rs_alu_op_1(rs_alu_op_1),
    .rs_cz_1(rs_cz_1), .rs_tag_a_1(rs_tag_a_1), .rs_tag_b_1(rs_tag_b_1),
    .rs_data_a_1(rs_data_a_1), .rs_data_b_1(rs_data_b_1), .rs_valid_a_1(rs_valid_a_1),
    .rs_valid_b_1(rs_valid_b_1), .rs_imm_1(rs_imm_1), .rs_pc_1(rs_pc_1),
    .rs_alu_en_1(rs_alu_en_1), .rs_mem_read_1(rs_mem_read_1), .rs_mem_write_1(rs_mem_write_1),
    .rs_reg_write_1(rs_reg_write_1), .rs_branch_1(rs_branch_1), .rs_jump_1(rs_jump_1),
    .rs_cmp_1(rs_cmp_1), .rs_rrf_dest_1(rs_rrf_dest_1),
    .rs_valid_2(rs_valid_2), .rs_opcode_2(rs_opcode_2), .rs_alu_op_2(rs_alu_op_2),
    .rs_cz_2(rs_cz_2), .rs_tag_a_2(rs_tag_a_2), .rs_tag_b_2(rs_tag_b_2),
    .rs_data_a_2(rs_data_a_2), .rs_data_b_2(rs_data_b_2), .rs_valid_a_2(rs_valid_a_2),
    .rs_valid_b_2(rs_valid_b_2), .rs_imm_2(rs_imm_2), .rs_pc_2(rs_pc_2),
    .rs_alu_en_2(rs_alu_en_2), .rs_mem_read_2(rs_mem_read_2), .rs_mem_write_2(rs_mem_write_2),
    .rs_reg_write_2(rs_reg_write_2), .rs_branch_2(rs_branch_2), .rs_jump_2(rs_jump_2),
    .rs_cmp_2(rs_cmp_2), .rs_rrf_dest_2(rs_rrf_dest_2),
    .cdb_valid_1(cdb_valid_1), .cdb_tag_1(cdb_tag_1), .cdb_data_1(cdb_data_1),
    .cdb_valid_2(cdb_valid_2), .cdb_tag_2(cdb_tag_2), .cdb_data_2(cdb_data_2),
    .rs_full(rs_full), .rs_has_one_slot(rs_has_one_slot), .iss_ready(iss_ready),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_data_a(iss_data_a),
    .iss_data_b(iss_data_b), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rrf_dest(iss_rrf_dest),
    .iss_alu_en(iss_alu_en), .iss_alu_op(iss_alu_op), .iss_mem_read(iss_mem_read),
    .iss_mem_write(iss_mem_write), .iss_reg_write(iss_reg_write), .iss_branch(iss_branch),
    .iss_jump(iss_jump), .iss_cz(iss_cz), .iss_cmp(iss_cmp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      pc;
    logic [15:0]      da;
    logic [15:0]      db;
    logic [15:0]      imm;
    logic [11:0]      ctl;
    logic [3:0]       opcode;
    logic [TAG_W-1:0] dest;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_valid_1 = 1'b0; rs_valid_2 = 1'b0;
    cdb_valid_1 = 1'b0; cdb_valid_2 = 1'b0;
    flush = 1'b0;
  endtask

  // Control fields and immediate are derived from the PC so each instruction is distinct.
  task automatic drive_slot(input int k, input logic [15:0] pc,
                            input logic [TAG_W-1:0] ta, input logic va, input logic [15:0] da,
                            input logic [TAG_W-1:0] tbg, input logic vb, input logic [15:0] db,
                            input logic [TAG_W-1:0] dest);
    logic [15:0] c;
    c = pc ^ 16'h0a5c;
    if (k == 1) begin
      rs_valid_1 = 1'b1; rs_pc_1 = pc; rs_imm_1 = pc ^ 16'h5a5a; rs_opcode_1 = pc[4:1];
      rs_alu_op_1 = c[2:0]; rs_cz_1 = c[4:3]; rs_alu_en_1 = c[5]; rs_mem_read_1 = c[6];
      rs_mem_write_1 = c[7]; rs_reg_write_1 = c[8]; rs_branch_1 = c[9]; rs_jump_1 = c[10];
      rs_cmp_1 = c[11]; rs_rrf_dest_1 = dest;
      rs_tag_a_1 = ta; rs_valid_a_1 = va; rs_data_a_1 = da;
      rs_tag_b_1 = tbg; rs_valid_b_1 = vb; rs_data_b_1 = db;
    end else begin
      rs_valid_2 = 1'b1; rs_pc_2 = pc; rs_imm_2 = pc ^ 16'h5a5a; rs_opcode_2 = pc[4:1];
      rs_alu_op_2 = c[2:0]; rs_cz_2 = c[4:3]; rs_alu_en_2 = c[5]; rs_mem_read_2 = c[6];
      rs_mem_write_2 = c[7]; rs_reg_write_2 = c[8]; rs_branch_2 = c[9]; rs_jump_2 = c[10];
      rs_cmp_2 = c[11]; rs_rrf_dest_2 = dest;
      rs_tag_a_2 = ta; rs_valid_a_2 = va; rs_data_a_2 = da;
      rs_tag_b_2 = tbg; rs_valid_b_2 = vb; rs_data_b_2 = db;
    end
  endtask

  task automatic expect_issue(input logic [15:0] pc, input logic [15:0] da,
                              input logic [15:0] db, input logic [TAG_W-1:0] dest);
    exp_t e;
    logic [15:0] c;
    c = pc ^ 16'h0a5c;
    e.pc = pc; e.da = da; e.db = db; e.dest = dest;
    e.imm = pc ^ 16'h5a5a; e.ctl = c[11:0]; e.opcode = pc[4:1];
    sb.push_back(e);
  endtask

  task automatic cdb(input int k, input logic [TAG_W-1:0] tag, input logic [15:0] data);
    if (k == 1) begin cdb_valid_1 = 1'b1; cdb_tag_1 = tag; cdb_data_1 = data; end
    else begin cdb_valid_2 = 1'b1; cdb_tag_2 = tag; cdb_data_2 = data; end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check_eq(tag, sb.size(), 0);
  endtask

  // A transfer happens at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && iss_valid && iss_ready) begin
      check_eq("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("iss_pc", iss_pc, e.pc);
        check_eq("iss_data_a", iss_data_a, e.da);
        check_eq("iss_data_b", iss_data_b, e.db);
        check_eq("iss_imm", iss_imm, e.imm);
        check_eq("iss_opcode", iss_opcode, e.opcode);
        check_eq("iss_rrf_dest", iss_rrf_dest, e.dest);
        check_eq("iss_ctl", {iss_cmp, iss_jump, iss_branch, iss_reg_write, iss_mem_write,
                             iss_mem_read, iss_alu_en, iss_cz, iss_alu_op}, e.ctl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iss_ready = 1'b0;
    clear_inputs();
    cdb_tag_1 = '0; cdb_tag_2 = '0; cdb_data_1 = '0; cdb_data_2 = '0;
    drive_slot(1, 16'h0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    drive_slot(2, 16'h0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    clear_inputs();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_iss_valid", iss_valid, 0);
    check_eq("rst_full", rs_full, 0);
    check_eq("rst_one_slot", rs_has_one_slot, 0);
    check_eq("rst_iss_pc", iss_pc, 0);
    check_eq("rst_iss_data_a", iss_data_a, 0);

    // Two ready instructions: in-order issue at N+2 and N+3.
    iss_ready = 1'b1;
    drive_slot(1, 16'h0010, '0, 1'b1, 16'h1111, '0, 1'b1, 16'h2222, 5'd1);
    drive_slot(2, 16'h0012, '0, 1'b1, 16'h3333, '0, 1'b1, 16'h4444, 5'd2);
    expect_issue(16'h0010, 16'h1111, 16'h2222, 5'd1);
    expect_issue(16'h0012, 16'h3333, 16'h4444, 5'd2);
    tick(); clear_inputs();
    check_eq("t1_n1_valid", iss_valid, 0);
    tick();
    check_eq("t1_n2_valid", iss_valid, 1);
    check_eq("t1_n2_pc", iss_pc, 16'h0010);
    tick();
    check_eq("t1_n3_pc", iss_pc, 16'h0012);
    tick();
    check_eq("t1_n4_valid", iss_valid, 0);
    check_eq("t1_one_slot", rs_has_one_slot, 0);

    // Wakeup via CDB; both buses carry tag 5 and bus 1 must win.
    drive_slot(1, 16'h0020, 5'd5, 1'b0, 16'hdead, '0, 1'b1, 16'h5555, 5'd3);
    expect_issue(16'h0020, 16'hbeef, 16'h5555, 5'd3);
    tick(); clear_inputs();
    tick();
    check_eq("t2_waiting", iss_valid, 0);
    cdb(1, 5'd5, 16'hbeef);
    cdb(2, 5'd5, 16'hbad0);
    tick(); clear_inputs();
    check_eq("t2_m1_valid", iss_valid, 0);
    tick();
    check_eq("t2_m2_valid", iss_valid, 1);
    check_eq("t2_data_a", iss_data_a, 16'hbeef);
    tick();

    // Same-cycle bypass at dispatch on bus 2.
    drive_slot(1, 16'h0030, '0, 1'b1, 16'h0101, 5'd7, 1'b0, 16'hdead, 5'd4);
    cdb(2, 5'd7, 16'h1234);
    expect_issue(16'h0030, 16'h0101, 16'h1234, 5'd4);
    tick(); clear_inputs();
    check_eq("t3_n1_valid", iss_valid, 0);
    tick();
    check_eq("t3_n2_valid", iss_valid, 1);
    check_eq("t3_data_b", iss_data_b, 16'h1234);
    tick();

    // Fill to DEPTH-1 then DEPTH with waiting entries; then hold the issue register.
    iss_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      expect_issue(16'h0100 + 16'(2 * i), 16'h9999, 16'h0b00, TAG_W'(i + 8));
    end
    for (int p = 0; p < 3; p++) begin
      drive_slot(1, 16'h0100 + 16'(4 * p), 5'd9, 1'b0, 16'hdead, '0, 1'b1, 16'h0b00,
                 TAG_W'(2 * p + 8));
      drive_slot(2, 16'h0102 + 16'(4 * p), 5'd9, 1'b0, 16'hdead, '0, 1'b1, 16'h0b00,
                 TAG_W'(2 * p + 9));
      tick(); clear_inputs();
    end
    drive_slot(1, 16'h010c, 5'd9, 1'b0, 16'hdead, '0, 1'b1, 16'h0b00, 5'd14);
    tick(); clear_inputs();
    check_eq("t4_one_slot", rs_has_one_slot, 1);
    check_eq("t4_not_full", rs_full, 0);
    drive_slot(1, 16'h010e, 5'd9, 1'b0, 16'hdead, '0, 1'b1, 16'h0b00, 5'd15);
    tick(); clear_inputs();
    check_eq("t4_full", rs_full, 1);
    check_eq("t4_full_one_slot", rs_has_one_slot, 0);
    check_eq("t4_none_ready", iss_valid, 0);
    cdb(1, 5'd9, 16'h9999);
    tick(); clear_inputs();
    tick();
    check_eq("t4_m2_valid", iss_valid, 1);
    check_eq("t4_after_issue_full", rs_full, 0);
    check_eq("t4_after_issue_one", rs_has_one_slot, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t4_hold_valid", iss_valid, 1);
      check_eq("t4_hold_pc", iss_pc, 16'h0100);
    end
    iss_ready = 1'b1;
    drain("t4_drained");
    tick();

    // Both woken together: older (slot 1) first.
    drive_slot(1, 16'h0200, 5'd3, 1'b0, 16'hdead, '0, 1'b1, 16'h0c00, 5'd5);
    drive_slot(2, 16'h0202, 5'd4, 1'b0, 16'hdead, '0, 1'b1, 16'h0c01, 5'd6);
    expect_issue(16'h0200, 16'ha003, 16'h0c00, 5'd5);
    expect_issue(16'h0202, 16'ha004, 16'h0c01, 5'd6);
    tick(); clear_inputs();
    cdb(1, 5'd4, 16'ha004);
    cdb(2, 5'd3, 16'ha003);
    tick(); clear_inputs();
    tick();
    check_eq("t5_older_first", iss_pc, 16'h0200);
    drain("t5_drained");
    tick();

    // Older entry sits at a higher index than a younger one.
    drive_slot(1, 16'h0300, 5'd12, 1'b0, 16'hdead, '0, 1'b1, 16'h0d00, 5'd7);
    drive_slot(2, 16'h0302, 5'd13, 1'b0, 16'hdead, '0, 1'b1, 16'h0d01, 5'd8);
    expect_issue(16'h0300, 16'hc012, 16'h0d00, 5'd7);
    tick(); clear_inputs();
    cdb(1, 5'd12, 16'hc012);
    tick(); clear_inputs();
    tick();
    check_eq("t5b_first_pc", iss_pc, 16'h0300);
    drive_slot(1, 16'h0304, 5'd14, 1'b0, 16'hdead, '0, 1'b1, 16'h0d02, 5'd9);
    expect_issue(16'h0302, 16'hc013, 16'h0d01, 5'd8);
    expect_issue(16'h0304, 16'hc014, 16'h0d02, 5'd9);
    tick(); clear_inputs();
    cdb(1, 5'd14, 16'hc014);
    cdb(2, 5'd13, 16'hc013);
    tick(); clear_inputs();
    tick();
    check_eq("t5b_older_high_idx", iss_pc, 16'h0302);
    drain("t5b_drained");
    tick();

    // Flush with a held issue register and a same-cycle dispatch.
    iss_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drive_slot(1, 16'h0400 + 16'(4 * p), '0, 1'b1, 16'h0e00, '0, 1'b1, 16'h0e01, 5'd10);
      drive_slot(2, 16'h0402 + 16'(4 * p), '0, 1'b1, 16'h0e02, '0, 1'b1, 16'h0e03, 5'd11);
      tick(); clear_inputs();
    end
    drive_slot(1, 16'h0408, '0, 1'b1, 16'h0e04, '0, 1'b1, 16'h0e05, 5'd12);
    tick(); clear_inputs();
    check_eq("t6_held_valid", iss_valid, 1);
    flush = 1'b1;
    drive_slot(1, 16'h0500, '0, 1'b1, 16'h0f00, '0, 1'b1, 16'h0f01, 5'd13);
    tick(); clear_inputs();
    check_eq("t6_flush_valid", iss_valid, 0);
    check_eq("t6_flush_full", rs_full, 0);
    check_eq("t6_flush_one", rs_has_one_slot, 0);
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_no_issue", iss_valid, 0);
    end
    check_eq("sb_empty_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
